// File: rtl/mac_reg_pkg.sv
// Shared definitions for the MAC host register bus master: register map,
// command op codes, access request struct and top-level sequencer states.
package mac_reg_pkg;

    // Register word indices (byte address on CA is word*2)
    localparam logic [6:0] TX_HWMARK     = 7'd0;
    localparam logic [6:0] TX_LWMARK     = 7'd1;
    localparam logic [6:0] CPU_RD_ADDR   = 7'd28;
    localparam logic [6:0] CPU_RD_APPLY  = 7'd29;
    localparam logic [6:0] CPU_RD_GRANT  = 7'd30;
    localparam logic [6:0] CPU_RD_DOUT_L = 7'd31;
    localparam logic [6:0] CPU_RD_DOUT_H = 7'd32;
    localparam logic [6:0] LINE_LOOP_EN  = 7'd33;
    localparam logic [6:0] SPEED         = 7'd34;

    typedef enum logic [1:0] {
        OP_WRITE   = 2'b00,
        OP_READ    = 2'b01,
        OP_RMON    = 2'b10,
        OP_ILLEGAL = 2'b11
    } op_e;

    typedef struct packed {
        logic        wr;
        logic [6:0]  addr;
        logic [15:0] wdata;
    } acc_req_t;

    localparam logic [3:0] ST_IDLE     = 4'd0;
    localparam logic [3:0] ST_ACCESS   = 4'd1;
    localparam logic [3:0] ST_SET_ADDR = 4'd2;
    localparam logic [3:0] ST_APPLY    = 4'd3;
    localparam logic [3:0] ST_POLL     = 4'd4;
    localparam logic [3:0] ST_RD_LO    = 4'd5;
    localparam logic [3:0] ST_RD_HI    = 4'd6;
    localparam logic [3:0] ST_RELEASE  = 4'd7;
    localparam logic [3:0] ST_RSP      = 4'd8;

    function automatic logic [7:0] byte_addr(input logic [6:0] word);
        return {word, 1'b0};
    endfunction

endpackage

// File: rtl/mac_reg_bus_master_if.sv
// Command/response handshake plus the CSB/WRB/CA/CD register bus.
// master = bus initiator view, slave = command source / register block view.
interface mac_reg_bus_master_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [6:0]  cmd_addr;
    logic [15:0] cmd_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        CSB;
    logic        WRB;
    logic [7:0]  CA;
    logic [15:0] CD_wr;
    logic [15:0] CD_rd;

    modport master (
        input  cmd_valid, cmd_op, cmd_addr, cmd_wdata, CD_rd,
        output cmd_ready, rsp_valid, rsp_data, rsp_err, CSB, WRB, CA, CD_wr
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_addr, cmd_wdata, CD_rd,
        input  cmd_ready, rsp_valid, rsp_data, rsp_err, CSB, WRB, CA, CD_wr
    );
endinterface

// File: rtl/mac_reg_bus_access.sv
// Single register access engine: one strobe cycle, then a capture (read) or
// gap (write) cycle so CSB is always high between two strobes.
module mac_reg_bus_access
    import mac_reg_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  acc_req_t    req,
    output logic        idle,
    output logic        done,
    output logic [15:0] rdata,
    output logic        CSB,
    output logic        WRB,
    output logic [7:0]  CA,
    output logic [15:0] CD_wr,
    input  logic [15:0] CD_rd
);
    localparam logic [1:0] A_IDLE   = 2'd0;
    localparam logic [1:0] A_STROBE = 2'd1;
    localparam logic [1:0] A_CAPT   = 2'd2;
    localparam logic [1:0] A_GAP    = 2'd3;

    logic [1:0] st;

    always_ff @(posedge clk) begin
        if (rst) begin
            st    <= A_IDLE;
            CSB   <= 1'b1;
            WRB   <= 1'b1;
            CA    <= 8'h00;
            CD_wr <= 16'h0000;
        end else begin
            case (st)
                A_IDLE: if (start) begin
                    st  <= A_STROBE;
                    CSB <= 1'b0;
                    WRB <= ~req.wr;
                    CA  <= byte_addr(req.addr);
                    if (req.wr) CD_wr <= req.wdata;
                end
                A_STROBE: begin
                    CSB <= 1'b1;
                    WRB <= 1'b1;
                    st  <= WRB ? A_CAPT : A_GAP;
                end
                default: st <= A_IDLE;
            endcase
        end
    end

    // Writes complete on the strobe edge; reads complete once the slave's
    // registered data is visible in the capture cycle.
    assign done  = (st == A_STROBE && !WRB) || (st == A_CAPT);
    assign idle  = (st == A_IDLE);
    assign rdata = CD_rd;

endmodule

// File: rtl/mac_reg_bus_master.sv
// MAC register bus master: single writes/reads and the composite RMON
// counter read sequenced on top of mac_reg_bus_access.
module mac_reg_bus_master
    import mac_reg_pkg::*;
#(
    parameter int POLL_MAX = 64,
    parameter int POLL_W   = 7
) (
    input  logic                 Clk_reg,
    input  logic                 Reset,
    mac_reg_bus_master_if.master bus
);
    logic [3:0]        state;
    logic [POLL_W-1:0] poll_cnt;
    logic              tmo;
    logic              is_rd;
    logic [5:0]        rmon_addr;
    logic [15:0]       lo, hi;

    acc_req_t    req;
    logic        start, acc_idle, acc_done;
    logic [15:0] acc_rdata;
    logic        accept;
    op_e         op;

    assign op     = op_e'(bus.cmd_op);
    assign accept = bus.cmd_valid && bus.cmd_ready;

    always_comb begin
        req   = '{wr: 1'b1, addr: bus.cmd_addr, wdata: 16'h0000};
        start = 1'b0;
        case (state)
            ST_IDLE: begin
                req.wr    = (op == OP_WRITE);
                req.wdata = bus.cmd_wdata;
                start     = accept && (op == OP_WRITE || op == OP_READ);
            end
            ST_SET_ADDR: begin
                req.addr  = CPU_RD_ADDR;
                req.wdata = {10'h000, rmon_addr};
                start     = acc_idle;
            end
            ST_APPLY: begin
                req.addr  = CPU_RD_APPLY;
                req.wdata = 16'h0001;
                start     = acc_idle;
            end
            ST_POLL: begin
                req.wr   = 1'b0;
                req.addr = CPU_RD_GRANT;
                start    = acc_idle;
            end
            ST_RD_LO: begin
                req.wr   = 1'b0;
                req.addr = CPU_RD_DOUT_L;
                start    = acc_idle;
            end
            ST_RD_HI: begin
                req.wr   = 1'b0;
                req.addr = CPU_RD_DOUT_H;
                start    = acc_idle;
            end
            ST_RELEASE: begin
                req.addr = CPU_RD_APPLY;
                start    = acc_idle;
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk_reg) begin
        if (Reset) begin
            state         <= ST_IDLE;
            bus.cmd_ready <= 1'b0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_data  <= 32'h0;
            bus.rsp_err   <= 1'b0;
            poll_cnt      <= '0;
            tmo           <= 1'b0;
            is_rd         <= 1'b0;
            rmon_addr     <= 6'h00;
            lo            <= 16'h0000;
            hi            <= 16'h0000;
        end else begin
            bus.rsp_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        bus.cmd_ready <= 1'b0;
                        rmon_addr     <= bus.cmd_addr[5:0];
                        is_rd         <= (op == OP_READ);
                        poll_cnt      <= '0;
                        tmo           <= 1'b0;
                        case (op)
                            OP_WRITE, OP_READ: state <= ST_ACCESS;
                            OP_RMON:           state <= ST_SET_ADDR;
                            default: begin
                                state         <= ST_RSP;
                                bus.rsp_valid <= 1'b1;
                                bus.rsp_data  <= 32'h0;
                                bus.rsp_err   <= 1'b1;
                            end
                        endcase
                    end else begin
                        bus.cmd_ready <= 1'b1;
                    end
                end
                ST_ACCESS: if (acc_done) begin
                    state         <= ST_RSP;
                    bus.rsp_valid <= 1'b1;
                    bus.rsp_err   <= 1'b0;
                    bus.rsp_data  <= is_rd ? {16'h0000, acc_rdata} : 32'h0;
                end
                ST_SET_ADDR: if (acc_done) state <= ST_APPLY;
                ST_APPLY:    if (acc_done) state <= ST_POLL;
                ST_POLL: if (acc_done) begin
                    if (acc_rdata[0]) begin
                        state <= ST_RD_LO;
                    end else begin
                        poll_cnt <= poll_cnt + POLL_W'(1);
                        // Last allowed poll came back without grant: give up
                        if (poll_cnt == POLL_W'(POLL_MAX - 1)) begin
                            tmo   <= 1'b1;
                            state <= ST_RELEASE;
                        end
                    end
                end
                ST_RD_LO: if (acc_done) begin
                    lo    <= acc_rdata;
                    state <= ST_RD_HI;
                end
                ST_RD_HI: if (acc_done) begin
                    hi    <= acc_rdata;
                    state <= ST_RELEASE;
                end
                ST_RELEASE: if (acc_done) begin
                    state         <= ST_RSP;
                    bus.rsp_valid <= 1'b1;
                    bus.rsp_err   <= tmo;
                    bus.rsp_data  <= tmo ? 32'h0 : {hi, lo};
                end
                ST_RSP: begin
                    state         <= ST_IDLE;
                    bus.cmd_ready <= 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    mac_reg_bus_access u_acc (
        .clk   (Clk_reg),
        .rst   (Reset),
        .start (start),
        .req   (req),
        .idle  (acc_idle),
        .done  (acc_done),
        .rdata (acc_rdata),
        .CSB   (bus.CSB),
        .WRB   (bus.WRB),
        .CA    (bus.CA),
        .CD_wr (bus.CD_wr),
        .CD_rd (bus.CD_rd)
    );

endmodule

// File: tb/tb_mac_reg_bus_master.sv
// Directed bench for mac_reg_bus_master with a register slave model and
// scoreboards for expected bus strobes and expected responses.
module tb_mac_reg_bus_master;
    import mac_reg_pkg::*;

    logic Clk_reg = 1'b0;
    logic Reset   = 1'b1;
    always #5 Clk_reg = ~Clk_reg;

    mac_reg_bus_master_if bus ();

    mac_reg_bus_master #(.POLL_MAX(64), .POLL_W(7)) dut (
        .Clk_reg (Clk_reg),
        .Reset   (Reset),
        .bus     (bus.master)
    );

    typedef struct packed {
        logic        wr;
        logic [7:0]  ca;
        logic [15:0] cd;
    } bus_t;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } rsp_t;

    bus_t exp_bus[$];
    rsp_t exp_rsp[$];
    int   checks = 0;
    int   errors = 0;
    bit   bus_chk_en = 1'b1;
    logic prev_csb = 1'b1;

    // Slave model: CD_rd registered on the read strobe edge
    logic [15:0] sregs [0:127];
    int          poll_n;
    int          grant_after = 0;

    always @(posedge Clk_reg) begin
        if (Reset) begin
            for (int i = 0; i < 128; i++) sregs[i] <= 16'h0000;
            sregs[26]  <= 16'h2710;
            sregs[31]  <= 16'hBEEF;
            sregs[32]  <= 16'hDEAD;
            sregs[34]  <= 16'h0004;
            bus.CD_rd  <= 16'h0000;
            poll_n     <= 0;
        end else if (!bus.CSB) begin
            if (!bus.WRB) begin
                sregs[bus.CA[7:1]] <= bus.CD_wr;
                if (bus.CA[7:1] == 7'd29 && bus.CD_wr[0]) poll_n <= 0;
            end else if (bus.CA[7:1] == 7'd30) begin
                poll_n    <= poll_n + 1;
                bus.CD_rd <= (grant_after != 0 && poll_n + 1 >= grant_after) ? 16'h0001 : 16'h0000;
            end else begin
                bus.CD_rd <= sregs[bus.CA[7:1]];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    always @(negedge Clk_reg) begin
        if (!Reset && bus_chk_en && !bus.CSB) begin
            check("csb_gap", 32'(prev_csb), 32'd1);
            if (exp_bus.size() == 0) begin
                check("bus_unexpected_strobe", 32'(exp_bus.size()), 32'd1);
            end else begin
                check("bus_wrb", 32'(bus.WRB), 32'(!exp_bus[0].wr));
                check("bus_ca", 32'(bus.CA), 32'(exp_bus[0].ca));
                if (exp_bus[0].wr) check("bus_cd_wr", 32'(bus.CD_wr), 32'(exp_bus[0].cd));
                void'(exp_bus.pop_front());
            end
        end
        prev_csb <= bus.CSB;
    end

    always @(negedge Clk_reg) begin
        if (!Reset && bus.rsp_valid) begin
            if (exp_rsp.size() == 0) begin
                check("rsp_unexpected", 32'(exp_rsp.size()), 32'd1);
            end else begin
                check("rsp_data", bus.rsp_data, exp_rsp[0].data);
                check("rsp_err", 32'(bus.rsp_err), 32'(exp_rsp[0].err));
                void'(exp_rsp.pop_front());
            end
        end
    end

    task automatic exp_wr(input logic [6:0] word, input logic [15:0] data);
        exp_bus.push_back('{wr: 1'b1, ca: {word, 1'b0}, cd: data});
    endtask

    task automatic exp_rd(input logic [6:0] word);
        exp_bus.push_back('{wr: 1'b0, ca: {word, 1'b0}, cd: 16'h0000});
    endtask

    // Issue one command; exp_lat > 0 checks cycles from accept edge to rsp_valid
    task automatic send(input logic [1:0] op, input logic [6:0] addr, input logic [15:0] wdata,
                        input int exp_lat, input logic [31:0] exp_data, input logic exp_err);
        int n;
        n = 0;
        @(negedge Clk_reg);
        while (!bus.cmd_ready && n < 50) begin
            @(negedge Clk_reg);
            n++;
        end
        check("cmd_ready_wait", 32'(bus.cmd_ready), 32'd1);
        if (!bus.cmd_ready) return;
        exp_rsp.push_back('{data: exp_data, err: exp_err});
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_addr  = addr;
        bus.cmd_wdata = wdata;
        @(posedge Clk_reg);
        #1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'($urandom);
        bus.cmd_addr  = 7'($urandom);
        bus.cmd_wdata = 16'($urandom);
        n = 0;
        do begin
            @(negedge Clk_reg);
            n++;
        end while (!bus.rsp_valid && n < 1000);
        check("rsp_seen", 32'(bus.rsp_valid), 32'd1);
        if (exp_lat > 0) check("rsp_latency", 32'(n), 32'(exp_lat));
        @(negedge Clk_reg);
        check("ready_after_rsp", 32'(bus.cmd_ready), 32'd1);
    endtask

    initial begin
        int n;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'b00;
        bus.cmd_addr  = 7'h00;
        bus.cmd_wdata = 16'h0000;

        // Reset values
        repeat (3) @(posedge Clk_reg);
        #1;
        check("rst_csb", 32'(bus.CSB), 32'd1);
        check("rst_wrb", 32'(bus.WRB), 32'd1);
        check("rst_ca", 32'(bus.CA), 32'd0);
        check("rst_cd_wr", 32'(bus.CD_wr), 32'd0);
        check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_rsp_data", bus.rsp_data, 32'd0);
        check("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
        Reset = 1'b0;
        @(posedge Clk_reg);
        #1;
        check("ready_after_reset", 32'(bus.cmd_ready), 32'd1);

        // Single read of slave reset value
        exp_rd(7'd26);
        send(OP_READ, 7'd26, 16'h0000, 3, 32'h0000_2710, 1'b0);

        // Write then readback
        exp_wr(7'd1, 16'h0019);
        send(OP_WRITE, 7'd1, 16'h0019, 2, 32'h0, 1'b0);
        exp_rd(7'd1);
        send(OP_READ, 7'd1, 16'h0000, 3, 32'h0000_0019, 1'b0);
        exp_wr(LINE_LOOP_EN, 16'hA5C3);
        send(OP_WRITE, LINE_LOOP_EN, 16'hA5C3, 2, 32'h0, 1'b0);
        exp_rd(LINE_LOOP_EN);
        send(OP_READ, LINE_LOOP_EN, 16'h0000, 3, 32'h0000_A5C3, 1'b0);

        // RMON read, grant on the 3rd poll; addr bit 6 must not reach reg 28
        grant_after = 3;
        exp_wr(7'd28, 16'h0005);
        exp_wr(7'd29, 16'h0001);
        repeat (3) exp_rd(7'd30);
        exp_rd(7'd31);
        exp_rd(7'd32);
        exp_wr(7'd29, 16'h0000);
        send(OP_RMON, 7'h45, 16'h0000, 0, 32'hDEAD_BEEF, 1'b0);

        // Illegal op: no strobes, error one cycle after accept
        send(OP_ILLEGAL, 7'd3, 16'h1234, 1, 32'h0, 1'b1);

        // RMON timeout: exactly 64 polls
        grant_after = 0;
        exp_wr(7'd28, 16'h003F);
        exp_wr(7'd29, 16'h0001);
        repeat (64) exp_rd(7'd30);
        exp_wr(7'd29, 16'h0000);
        send(OP_RMON, 7'h3F, 16'h0000, 0, 32'h0, 1'b1);

        // Reset during POLL
        bus_chk_en = 1'b0;
        n = 0;
        @(negedge Clk_reg);
        while (!bus.cmd_ready && n < 50) begin
            @(negedge Clk_reg);
            n++;
        end
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = OP_RMON;
        bus.cmd_addr  = 7'd2;
        @(posedge Clk_reg);
        #1;
        bus.cmd_valid = 1'b0;
        n = 0;
        do begin
            @(negedge Clk_reg);
            n++;
        end while (!(!bus.CSB && bus.WRB && bus.CA == 8'h3C) && n < 100);
        check("poll_reached", 32'(bus.CA), 32'h3C);
        Reset = 1'b1;
        @(posedge Clk_reg);
        #1;
        check("midrst_csb", 32'(bus.CSB), 32'd1);
        check("midrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("midrst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        Reset = 1'b0;
        @(posedge Clk_reg);
        #1;
        check("midrst_ready_after", 32'(bus.cmd_ready), 32'd1);
        bus_chk_en = 1'b1;
        exp_rd(SPEED);
        send(OP_READ, SPEED, 16'h0000, 3, 32'h0000_0004, 1'b0);

        repeat (3) @(negedge Clk_reg);
        check("bus_queue_empty", 32'(exp_bus.size()), 32'd0);
        check("rsp_queue_empty", 32'(exp_rsp.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
